// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file port driver.
//   state_t      : sequencer FSM states (RWAIT only reachable with READ_LAT=1)
//   DEF_ADDR_W   : default register address width
//   DEF_DATA_W   : default register data width
//   read_lat_ok  : legality check for the register-file read latency
package regfile_pkg;

  localparam int DEF_ADDR_W = 1;
  localparam int DEF_DATA_W = 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RWAIT
  } state_t;

  function automatic bit read_lat_ok(int lat);
    return (lat == 0) || (lat == 1);
  endfunction

endpackage

// File: rtl/regfile_port_driver_if.sv
// Command/response stream bundle for regfile_port_driver.
//   cmd_valid/cmd_ready : command handshake
//   cmd_write           : 1 = write, 0 = read
//   cmd_addr/cmd_wdata  : target register and write data
//   rsp_valid/rsp_ready : read-result handshake
//   rsp_rdata           : read result
// master = agent issuing commands, slave = the driver.
interface regfile_port_driver_if #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 1
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/regfile_rsp_fifo.sv
// Circular-buffer response FIFO for read results.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : enqueue din (caller guarantees space, or a same-edge pop)
//   pop        : dequeue head (ignored when empty)
//   full/empty : occupancy flags
//   count      : number of stored entries
//   head       : oldest entry, stable until popped
module regfile_rsp_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_port_driver.sv
// Command-to-port sequencer owning the access side of a register file.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : command/response streams (slave side)
//   regWrite, writeReg, writeData : register-file write port
//   readReg, readData             : register-file read port
//   busy       : an access is in progress (FSM not IDLE)
// One access at a time; read results are queued in regfile_rsp_fifo.
module regfile_port_driver
  import regfile_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int READ_LAT  = 0,
  parameter int RSP_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_port_driver_if.slave bus,
  output logic                regWrite,
  output logic [ADDR_W-1:0]   writeReg,
  output logic [DATA_W-1:0]   writeData,
  output logic [ADDR_W-1:0]   readReg,
  input  logic [DATA_W-1:0]   readData,
  output logic                busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  if (!read_lat_ok(READ_LAT) || (RSP_DEPTH < 1)) begin : g_bad_param
    $error("regfile_port_driver: READ_LAT must be 0 or 1 and RSP_DEPTH >= 1");
  end

  state_t           state;
  state_t           state_nxt;
  logic             rdy_en;
  logic             accept;
  logic             in_flight;
  logic             read_done;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [DATA_W-1:0] fifo_head;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.cmd_write ? WRITE : READ;
      WRITE:   state_nxt = IDLE;
      READ:    state_nxt = (READ_LAT == 1) ? RWAIT : IDLE;
      RWAIT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    regWrite  = (state == WRITE);
    busy      = (state != IDLE);
    in_flight = (state == READ) || (state == RWAIT);
    read_done = ((state == READ) && (READ_LAT == 0)) || (state == RWAIT);
  end

  // rdy_en keeps cmd_ready low for the cycle following a reset edge even if
  // rst_n has already been released; the rst_n term covers the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign bus.cmd_ready = rst_n && rdy_en && (state == IDLE) &&
                         ((int'(fifo_count) + int'(in_flight)) < RSP_DEPTH);

  // Port registers: loaded only on acceptance, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      writeReg  <= '0;
      writeData <= '0;
      readReg   <= '0;
    end else if (accept) begin
      if (bus.cmd_write) begin
        writeReg  <= bus.cmd_addr;
        writeData <= bus.cmd_wdata;
      end else begin
        readReg <= bus.cmd_addr;
      end
    end
  end

  // A slot is reserved at acceptance, so the full guard never drops data in
  // practice; a same-edge pop makes a push into a full FIFO legal.
  assign pop  = bus.rsp_valid && bus.rsp_ready;
  assign push = read_done && (!fifo_full || pop);

  regfile_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (readData),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_rdata = fifo_head;

endmodule

// File: tb/tb_regfile_port_driver.sv
// Directed bench for regfile_port_driver: one instance with combinational
// read (READ_LAT=0) and one with registered read (READ_LAT=1), each attached
// to a small behavioural register file.
module tb_regfile_port_driver;

  logic clk;
  logic rst_n;

  logic       regWrite0, busy0, regWrite1, busy1;
  logic [1:0] writeReg0, readReg0, writeReg1, readReg1;
  logic [7:0] writeData0, readData0, writeData1, readData1;

  logic [7:0] rf0 [4];
  logic [7:0] rf1 [4];

  int vectors     = 0;
  int miscompares = 0;

  regfile_port_driver_if #(.ADDR_W(2), .DATA_W(8)) bus0 ();
  regfile_port_driver_if #(.ADDR_W(2), .DATA_W(8)) bus1 ();

  regfile_port_driver #(
    .ADDR_W(2), .DATA_W(8), .READ_LAT(0), .RSP_DEPTH(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .regWrite(regWrite0), .writeReg(writeReg0), .writeData(writeData0),
    .readReg(readReg0), .readData(readData0), .busy(busy0)
  );

  regfile_port_driver #(
    .ADDR_W(2), .DATA_W(8), .READ_LAT(1), .RSP_DEPTH(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .regWrite(regWrite1), .writeReg(writeReg1), .writeData(writeData1),
    .readReg(readReg1), .readData(readData1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (regWrite0) rf0[writeReg0] <= writeData0;
  assign readData0 = rf0[readReg0];

  always @(posedge clk) begin
    if (regWrite1) rf1[writeReg1] <= writeData1;
    readData1 <= rf1[readReg1];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a command at a negedge; it is accepted at the next posedge.
  task automatic issue0(logic w, logic [1:0] a, logic [7:0] d);
    bus0.cmd_valid = 1'b1; bus0.cmd_write = w; bus0.cmd_addr = a; bus0.cmd_wdata = d;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
  endtask

  task automatic issue1(logic w, logic [1:0] a, logic [7:0] d);
    bus1.cmd_valid = 1'b1; bus1.cmd_write = w; bus1.cmd_addr = a; bus1.cmd_wdata = d;
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_addr = '0;
    bus0.cmd_wdata = '0;   bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_write = 1'b0; bus1.cmd_addr = '0;
    bus1.cmd_wdata = '0;   bus1.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", bus0.cmd_ready, 0);
    chk("rst_rsp_valid", bus0.rsp_valid, 0);
    chk("rst_regWrite", regWrite0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_writeReg", writeReg0, 0);
    chk("rst_writeData", writeData0, 0);
    chk("rst_readReg", readReg0, 0);
    rst_n = 1'b1;
    #1 chk("rel_ready_lag", bus0.cmd_ready, 0);
    @(negedge clk);
    chk("rel_ready_up0", bus0.cmd_ready, 1);
    chk("rel_ready_up1", bus1.cmd_ready, 1);

    // Write addr 1 data 1, then read it back
    issue0(1'b1, 2'd1, 8'h01);
    chk("wr_pulse", regWrite0, 1);
    chk("wr_addr", writeReg0, 1);
    chk("wr_data", writeData0, 8'h01);
    chk("wr_busy", busy0, 1);
    chk("wr_not_ready", bus0.cmd_ready, 0);
    @(negedge clk);
    chk("wr_pulse_end", regWrite0, 0);
    chk("wr_idle", busy0, 0);
    chk("wr_ready_back", bus0.cmd_ready, 1);
    issue0(1'b1, 2'd2, 8'hA5);
    @(negedge clk);
    issue0(1'b1, 2'd3, 8'h5C);
    @(negedge clk);
    issue0(1'b0, 2'd1, 8'h00);
    chk("rd_readReg", readReg0, 1);
    chk("rd_busy", busy0, 1);
    chk("rd_no_rsp_yet", bus0.rsp_valid, 0);
    @(negedge clk);
    chk("rd_rsp_valid", bus0.rsp_valid, 1);
    chk("rd_rsp_data", bus0.rsp_rdata, 8'h01);
    chk("rd_idle", busy0, 0);
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rd_popped", bus0.rsp_valid, 0);
    bus0.rsp_ready = 1'b0;

    // Backpressure: two results fill the FIFO, third read must wait
    issue0(1'b0, 2'd2, 8'h00);
    @(negedge clk);
    chk("bp_one_rsp", bus0.rsp_rdata, 8'hA5);
    chk("bp_ready_space", bus0.cmd_ready, 1);
    issue0(1'b0, 2'd3, 8'h00);
    @(negedge clk);
    chk("bp_full_ready", bus0.cmd_ready, 0);
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b0; bus0.cmd_addr = 2'd1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_ready", bus0.cmd_ready, 0);
      chk("bp_head_stable", bus0.rsp_rdata, 8'hA5);
      chk("bp_no_issue", busy0, 0);
    end
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_order_2nd", bus0.rsp_rdata, 8'h5C);
    chk("bp_valid_2nd", bus0.rsp_valid, 1);
    chk("bp_ready_again", bus0.cmd_ready, 1);
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    chk("bp_third_busy", busy0, 1);
    chk("bp_third_addr", readReg0, 1);
    chk("bp_drained", bus0.rsp_valid, 0);
    @(negedge clk);
    chk("bp_third_valid", bus0.rsp_valid, 1);
    chk("bp_third_data", bus0.rsp_rdata, 8'h01);
    @(negedge clk);
    chk("bp_third_popped", bus0.rsp_valid, 0);
    bus0.rsp_ready = 1'b0;

    // Push and pop on the same edge
    issue0(1'b0, 2'd2, 8'h00);
    @(negedge clk);
    issue0(1'b0, 2'd3, 8'h00);
    chk("pp_head_before", bus0.rsp_rdata, 8'hA5);
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    chk("pp_valid", bus0.rsp_valid, 1);
    chk("pp_data", bus0.rsp_rdata, 8'h5C);
    chk("pp_count_kept", bus0.cmd_ready, 1);
    @(negedge clk);
    chk("pp_empty", bus0.rsp_valid, 0);
    bus0.rsp_ready = 1'b0;

    // Reset in the accept cycle of a write, with a result pending
    issue0(1'b0, 2'd2, 8'h00);
    @(negedge clk);
    chk("mr_pending", bus0.rsp_valid, 1);
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b1; bus0.cmd_addr = 2'd1;
    bus0.cmd_wdata = 8'h77; rst_n = 1'b0;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    chk("mr_regWrite", regWrite0, 0);
    chk("mr_busy", busy0, 0);
    chk("mr_rsp_valid", bus0.rsp_valid, 0);
    chk("mr_cmd_ready", bus0.cmd_ready, 0);
    chk("mr_writeReg", writeReg0, 0);
    chk("mr_writeData", writeData0, 0);
    chk("mr_readReg", readReg0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_regWrite_after", regWrite0, 0);
    issue0(1'b0, 2'd1, 8'h00);
    @(negedge clk);
    chk("mr_readback_valid", bus0.rsp_valid, 1);
    chk("mr_readback_data", bus0.rsp_rdata, 8'h01);
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    bus0.rsp_ready = 1'b0;

    // Idle stability
    issue0(1'b1, 2'd3, 8'hC3);
    @(negedge clk);
    repeat (10) begin
      chk("idle_regWrite", regWrite0, 0);
      chk("idle_writeReg", writeReg0, 3);
      chk("idle_writeData", writeData0, 8'hC3);
      chk("idle_readReg", readReg0, 1);
      @(negedge clk);
    end

    // Registered-read instance
    issue1(1'b1, 2'd0, 8'h01);
    @(negedge clk);
    issue1(1'b1, 2'd2, 8'h3C);
    @(negedge clk);
    issue1(1'b0, 2'd0, 8'h00);
    chk("l1_busy_t1", busy1, 1);
    chk("l1_readReg", readReg1, 0);
    chk("l1_no_rsp_t1", bus1.rsp_valid, 0);
    @(negedge clk);
    chk("l1_busy_t2", busy1, 1);
    chk("l1_no_rsp_t2", bus1.rsp_valid, 0);
    chk("l1_not_ready_t2", bus1.cmd_ready, 0);
    @(negedge clk);
    chk("l1_rsp_valid_t3", bus1.rsp_valid, 1);
    chk("l1_rsp_data", bus1.rsp_rdata, 8'h01);
    chk("l1_idle_t3", busy1, 0);
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    chk("l1_popped", bus1.rsp_valid, 0);
    issue1(1'b0, 2'd2, 8'h00);
    chk("l1_readReg2", readReg1, 2);
    @(negedge clk);
    @(negedge clk);
    chk("l1_rsp_valid2", bus1.rsp_valid, 1);
    chk("l1_rsp_data2", bus1.rsp_rdata, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
